// File: rtl/cla_addsub_seq_pkg.sv
// Shared types and constants for the sequential group-at-a-time add/subtract unit.
package cla_addsub_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   localparam int unsigned DEF_GROUP_W = 4;
   localparam int unsigned DEF_WIDTH   = 16;

   // Width of the group index counter; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned ngroups);
      return (ngroups > 1) ? $clog2(ngroups) : 1;
   endfunction

endpackage

// File: rtl/cla_addsub_seq_group.sv
// One lookahead group: propagate/generate per bit, carry recurrence, sum.
module cla_group4
   import cla_addsub_seq_pkg::*;
#(
   parameter int unsigned W = DEF_GROUP_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   logic [W-1:0] p;
   logic [W-1:0] g;
   logic [W-1:0] c;

   // Carry out of every bit position, then sum from the incoming carries.
   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c    = '0;
      c[0] = g[0] | (p[0] & cin);
      for (int unsigned i = 1; i < W; i++) begin
         c[i] = g[i] | (p[i] & c[i-1]);
      end
      carry = c;
      sum   = p ^ {c[W-2:0], cin};
   end

endmodule

// File: rtl/cla_addsub_seq.sv
// Multi-cycle add/subtract: one lookahead group per cycle, group carry held in a register.
module cla_addsub_seq
   import cla_addsub_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned GROUP_W = DEF_GROUP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_overflow,
   output logic             out_zero
);

   localparam int unsigned NGROUPS = WIDTH / GROUP_W;
   localparam int unsigned IW      = idx_w(NGROUPS);

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;

   logic [GROUP_W-1:0] ga, gb, gsum, gcarry;
   logic [WIDTH-1:0]   grp_mask;
   logic [WIDTH-1:0]   merged;
   logic               last;

   // Shifts select the active group so the index width never has to match the slice width.
   assign ga       = GROUP_W'(a_q >> (idx_q * GROUP_W));
   assign gb       = GROUP_W'(b_q >> (idx_q * GROUP_W));
   assign grp_mask = WIDTH'({GROUP_W{1'b1}}) << (idx_q * GROUP_W);
   assign merged   = (acc_q & ~grp_mask) | (WIDTH'(gsum) << (idx_q * GROUP_W));
   assign last     = (idx_q == IW'(NGROUPS - 1));

   cla_group4 #(.W(GROUP_W)) u_group (
      .a     (ga),
      .b     (gb),
      .cin   (carry_q),
      .sum   (gsum),
      .carry (gcarry)
   );

   assign in_ready     = (state_q == IDLE);
   assign out_valid    = (state_q == DONE);
   assign out_result   = res_q;
   assign out_carry    = cout_q;
   assign out_overflow = ovf_q;
   assign out_zero     = zero_q;

   // Next-state and datapath updates; the working accumulator is separate from the
   // published result so outputs stay frozen while the next operation is in flight.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b ^ {WIDTH{in_sub}};
               carry_d = in_sub;
               idx_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d   = merged;
            carry_d = gcarry[GROUP_W-1];
            if (last) begin
               res_d   = merged;
               cout_d  = gcarry[GROUP_W-1];
               ovf_d   = gcarry[GROUP_W-1] ^ gcarry[GROUP_W-2];
               zero_d  = (merged == '0);
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and data registers with synchronous reset overriding any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Bench for cla_addsub_seq: behavioural reference checked every cycle, plus directed cases.
module tb_cla_addsub_seq;

   localparam int NG = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sub = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        in_ready, out_valid, out_carry, out_overflow, out_zero;
   logic [15:0] out_result;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model state: phase 0 idle, 1..NG computing, NG+1 presenting.
   int          m_phase = 0;
   logic [15:0] m_res = '0, p_res = '0;
   logic        m_c = 1'b0, m_o = 1'b0, m_z = 1'b0;
   logic        p_c = 1'b0, p_o = 1'b0, p_z = 1'b0;

   always #5 clk = ~clk;

   cla_addsub_seq #(.WIDTH(16), .GROUP_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_sub       (in_sub),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_carry    (out_carry),
      .out_overflow (out_overflow),
      .out_zero     (out_zero)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic: unsigned carry/no-borrow and signed range overflow.
   function automatic void ref_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  output logic [15:0] r, output logic c, output logic o,
                                  output logic z);
      int ua, ub, t, si;
      ua = int'(a);
      ub = int'(b);
      if (s) begin
         r  = a - b;
         c  = (ua >= ub);
         si = int'($signed(a)) - int'($signed(b));
      end else begin
         t  = ua + ub;
         r  = 16'(t);
         c  = (t > 65535);
         si = int'($signed(a)) + int'($signed(b));
      end
      o = (si > 32767) || (si < -32768);
      z = (r == 16'h0000);
   endfunction

   // Reference model advances on each rising edge using the pre-edge inputs.
   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_res = '0; m_c = 1'b0; m_o = 1'b0; m_z = 1'b0;
      end else if (m_phase == 0) begin
         if (in_valid) begin
            ref_op(in_a, in_b, in_sub, p_res, p_c, p_o, p_z);
            m_phase = 1;
         end
      end else if (m_phase < NG) begin
         m_phase++;
      end else if (m_phase == NG) begin
         m_phase = NG + 1;
         m_res = p_res; m_c = p_c; m_o = p_o; m_z = p_z;
      end else if (out_ready) begin
         m_phase = 0;
      end
   end

   // Every cycle, all DUT outputs are compared with the model on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",  32'(in_ready),     32'(m_phase == 0));
         chk("out_valid", 32'(out_valid),    32'(m_phase == NG + 1));
         chk("result",    32'(out_result),   32'(m_res));
         chk("carry",     32'(out_carry),    32'(m_c));
         chk("overflow",  32'(out_overflow), 32'(m_o));
         chk("zero",      32'(out_zero),     32'(m_z));
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output int waited);
      in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
      waited = 0;
      while (1) begin
         @(negedge clk);
         waited++;
         if (in_ready) break;
         if (waited > 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
   endtask

   task automatic collect(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 100);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [15:0] er, input logic ec,
                           input logic eo, input logic ez);
      int w, lat;
      send(a, b, s, w);
      collect(lat);
      chk({name, "_latency"}, 32'(lat), 32'd4);
      chk({name, "_result"},  32'(out_result),   32'(er));
      chk({name, "_carry"},   32'(out_carry),    32'(ec));
      chk({name, "_ovf"},     32'(out_overflow), 32'(eo));
      chk({name, "_zero"},    32'(out_zero),     32'(ez));
      release_result();
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h8000;
         3: return 16'h7FFF;
         4: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      int w, lat;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset_in_ready",  32'(in_ready),   32'd1);
      chk("reset_out_valid", 32'(out_valid),  32'd0);
      chk("reset_result",    32'(out_result), 32'd0);
      rst = 1'b0;

      directed("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
      directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      directed("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      directed("sub_borrow",16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

      // Backpressure: result held with new operands pending, accepted right after release.
      send(16'h1234, 16'h0FFF, 1'b0, w);
      collect(lat);
      in_a = 16'h0101; in_b = 16'h0202; in_sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready",  32'(in_ready),   32'd0);
         chk("bp_out_valid", 32'(out_valid),  32'd1);
         chk("bp_result",    32'(out_result), 32'h2233);
         @(posedge clk); #1;
      end
      release_result();
      chk("bp_idle_ready", 32'(in_ready), 32'd1);
      send(16'h0101, 16'h0202, 1'b0, w);
      chk("bp_accept_wait", 32'(w), 32'd1);
      collect(lat);
      chk("bp_latency", 32'(lat), 32'd4);
      chk("bp_result2", 32'(out_result), 32'h0303);
      release_result();

      // Reset during the second compute cycle discards the operation.
      send(16'h5555, 16'h1111, 1'b0, w);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_in_ready",  32'(in_ready),   32'd1);
      chk("rst_out_valid", 32'(out_valid),  32'd0);
      chk("rst_result",    32'(out_result), 32'd0);
      chk("rst_carry",     32'(out_carry),  32'd0);
      directed("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

      // Random traffic with random backpressure and occasional reset.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = pick();
         in_b      = pick();
         in_sub    = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 99) == 0);
         @(posedge clk); #1;
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_addsub_seq.md
Name: cla_addsub_seq

Overview:
- Multi-cycle 16-bit add/subtract unit; computes one 4-bit lookahead group per cycle and ripples the group carry through a register between cycles.
- Subtraction is two's complement: B is inverted and the initial carry is 1.
- Sits behind a valid/ready operand interface and in front of a valid/ready result interface.
- Is the area-lean companion of the combinational 16-bit CLA datapath: one group's lookahead logic reused over NGROUPS cycles.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP_W.
- GROUP_W, 4, bits processed per cycle (one lookahead group).
- NGROUPS, WIDTH/GROUP_W (derived localparam), number of CALC cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  operand request ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_result  out  WIDTH  sum/difference.
- out_carry  out  1  final carry-out (for subtract, 1 = no borrow).
- out_overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- out_zero  out  1  out_result == 0.

Behaviour:
- Reset: state <= IDLE, group index <= 0, carry reg <= 0, out_result/out_carry/out_overflow/out_zero <= 0. out_valid = 0. rst has priority over every handshake, and inputs are ignored while rst = 1.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state with no combinational in->out path.
- FSM states: IDLE, CALC, DONE.
- IDLE: on in_valid & in_ready:
  - latch a <= in_a, b <= in_b ^ {WIDTH{in_sub}}, carry <= in_sub, sub flag <= in_sub, idx <= 0;
  - go to CALC.
- CALC, each cycle:
  - group idx slice of a/b plus carry go through cla_group4;
  - sum goes to result slice idx; carry <= group carry-out;
  - on the last group (idx == NGROUPS-1), also register out_carry, out_overflow (from the group's internal carry into bit GROUP_W-1) and out_zero (on the completed result);
  - then go to DONE. Otherwise idx++.
- DONE: hold all result outputs stable. On out_ready, go to IDLE. Outputs keep their last values until the next completion; only out_valid drops.
- Latency: acceptance edge E; out_valid is high in the cycle after edge E+NGROUPS (4 cycles for defaults).
  - Minimum issue interval is NGROUPS+2 cycles: there is no accept in DONE, even if out_ready=1 in the same cycle.
- Backpressure: out_ready low holds DONE indefinitely, with in_ready = 0. The in_* operands are sampled only at acceptance, so changes during CALC/DONE have no effect.
- Arithmetic: modulo 2^WIDTH. Carry chain within a group is lookahead: C[i] = G[i] | P[i]&C[i-1], with P = a^b and G = a&b. Sum = P ^ {carries shifted, cin}.
- Reset mid-operation (CALC or DONE): the operation is discarded. The next cycle is IDLE with cleared outputs, and no partial result is ever presented.

Decomposition:
- Shared package:
  - state enum {IDLE, CALC, DONE};
  - constants GROUP_W = 4, default WIDTH = 16;
  - function for the idx counter width, clog2(NGROUPS).
- Sub-module cla_group4: combinational.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], carry[3:0] (carry[3] = group carry-out, carry[2] used for overflow).
- The top level holds the FSM, operand/result registers and flags.

Test Plan:
- Add 0x1234 + 0x0FFF -> out_result 0x2233, carry 0, overflow 0, zero 0. out_valid rises exactly 4 cycles after the accept edge.
- Add 0xFFFF + 0x0001 -> 0x0000, carry 1, zero 1, overflow 0. Add 0x7FFF + 0x0001 -> 0x8000, carry 0, overflow 1.
- Sub 0x8000 - 0x0001 -> 0x7FFF, carry 1 (no borrow), overflow 1. Sub 0x0003 - 0x0005 -> 0xFFFE, carry 0 (borrow), overflow 0.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE while in_valid = 1 with new operands.
  - in_ready stays 0 and the result stays stable.
  - After out_ready pulses, the next cycle is IDLE and the new operands are accepted then.
- Reset asserted for 1 cycle during the 2nd CALC cycle.
  - Next cycle: in_ready = 1, out_valid = 0, result/flags = 0.
  - A following 0x0001 + 0x0001 then yields 0x0002 with correct latency.
